// File: rtl/peri_write_collector.sv
// peri_write_collector: window-filtered capture of core peripheral writes into a
// first-word-fall-through FIFO drained over a valid/ready stream.
module peri_write_collector #(
   parameter int DEPTH = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter logic [ADDR_W-1:0] ADDR_LO = 16'h0000,
   parameter logic [ADDR_W-1:0] ADDR_HI = 16'hFFFF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     peri_web,
   input  logic [ADDR_W-1:0]        peri_addr,
   input  logic [DATA_W-1:0]        peri_datao,
   input  logic                     clr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic hit, push_req, pop, push_ok, drop;
   // signed compare on zero-extended operands keeps the full-range window from folding to a constant
   assign hit = ~peri_web
              & ($signed({1'b0, peri_addr}) >= $signed({1'b0, ADDR_LO}))
              & ($signed({1'b0, peri_addr}) <= $signed({1'b0, ADDR_HI}));
   assign push_req = hit & ~clr;
   assign out_valid = count != '0;
   assign full = count == CW'(DEPTH);
   assign pop = out_valid & out_ready & ~clr;
   assign push_ok = push_req & (~full | pop);
   assign drop = push_req & full & ~pop;
   assign out_addr = out_valid ? mem[rd_ptr][ADDR_W+DATA_W-1:DATA_W] : '0;
   assign out_data = out_valid ? mem[rd_ptr][DATA_W-1:0] : '0;
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop);
         if (drop) overflow <= 1'b1;
         if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end
   always_ff @(posedge clk)
      if (rst_n && push_ok) mem[wr_ptr] <= {peri_addr, peri_datao};
endmodule

// File: tb/tb_peri_write_collector.sv
// tb_peri_write_collector: vector table plus directed sequences for the write collector.
module tb_peri_write_collector;
   logic clk = 1'b0, rst_n = 1'b0, web = 1'b1, clr = 1'b0, rdy = 1'b0, rdy1 = 1'b0;
   logic [15:0] addr = '0, data = '0;
   logic v0, f0, o0, v1, f1, o1;
   logic [15:0] a0, d0, a1, d1;
   logic [3:0] c0, c1;
   logic [7:0] dc0, dc1;
   int checks = 0, errors = 0;

   typedef struct {
      logic web; logic [15:0] addr, data; logic rdy;
      logic ev; logic [15:0] ea, ed; logic [3:0] ec; logic ef, eo; logic [7:0] edc;
   } vec_t;
   vec_t tbl[$];

   peri_write_collector u0 (
      .clk(clk), .rst_n(rst_n), .peri_web(web), .peri_addr(addr), .peri_datao(data),
      .clr(clr), .out_valid(v0), .out_ready(rdy), .out_addr(a0), .out_data(d0),
      .count(c0), .full(f0), .overflow(o0), .drop_cnt(dc0));

   peri_write_collector #(.ADDR_LO(16'h0100), .ADDR_HI(16'h01FF)) u1 (
      .clk(clk), .rst_n(rst_n), .peri_web(web), .peri_addr(addr), .peri_datao(data),
      .clr(clr), .out_valid(v1), .out_ready(rdy1), .out_addr(a1), .out_data(d1),
      .count(c1), .full(f1), .overflow(o1), .drop_cnt(dc1));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", n, got, exp);
      end
   endtask

   task automatic step(input logic w, input logic [15:0] a, input logic [15:0] d, input logic r);
      web = w; addr = a; data = d; rdy = r;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic w, input logic [15:0] a, input logic [15:0] d, input logic r,
                      input logic ev, input logic [15:0] ea, input logic [15:0] ed,
                      input logic [3:0] ec, input logic ef, input logic eo, input logic [7:0] edc);
      tbl.push_back('{w, a, d, r, ev, ea, ed, ec, ef, eo, edc});
   endtask

   initial begin
      step(1'b1, 16'h0, 16'h0, 1'b0);
      step(1'b1, 16'h0, 16'h0, 1'b0);
      chk("rst valid", v0, 0); chk("rst count", c0, 0); chk("rst full", f0, 0);
      chk("rst ovf", o0, 0); chk("rst drop", dc0, 0); chk("rst addr", a0, 0); chk("rst data", d0, 0);
      rst_n = 1'b1;

      add(1, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 4'd0, 0, 0, 8'd0);
      add(0, 16'h0010, 16'h1234, 0, 1, 16'h0010, 16'h1234, 4'd1, 0, 0, 8'd0);
      add(1, 16'h0, 16'h0, 1, 0, 16'h0, 16'h0, 4'd0, 0, 0, 8'd0);
      add(1, 16'h0, 16'h0, 1, 0, 16'h0, 16'h0, 4'd0, 0, 0, 8'd0);
      for (int i = 0; i < 10; i++)
         add(0, 16'(16'h20 + i), 16'(i), 0, 1, 16'h0020, 16'h0000,
             4'(i < 8 ? i + 1 : 8), i >= 7, i >= 8, 8'(i >= 8 ? i - 7 : 0));
      add(0, 16'h0030, 16'hAAAA, 1, 1, 16'h0021, 16'h0001, 4'd8, 1, 1, 8'd2);
      for (int j = 1; j <= 8; j++)
         add(1, 16'h0, 16'h0, 1, j < 8,
             16'(j < 7 ? 16'h21 + j : (j == 7 ? 16'h30 : 0)),
             16'(j < 7 ? j + 1 : (j == 7 ? 16'hAAAA : 0)),
             4'(8 - j), 0, 1, 8'd2);

      foreach (tbl[i]) begin
         step(tbl[i].web, tbl[i].addr, tbl[i].data, tbl[i].rdy);
         chk($sformatf("v%0d valid", i), v0, tbl[i].ev);
         chk($sformatf("v%0d addr", i), a0, tbl[i].ea);
         chk($sformatf("v%0d data", i), d0, tbl[i].ed);
         chk($sformatf("v%0d count", i), c0, tbl[i].ec);
         chk($sformatf("v%0d full", i), f0, tbl[i].ef);
         chk($sformatf("v%0d ovf", i), o0, tbl[i].eo);
         chk($sformatf("v%0d drop", i), dc0, tbl[i].edc);
      end

      clr = 1'b1;
      step(1'b1, 16'h0, 16'h0, 1'b0);
      clr = 1'b0;
      chk("clr ovf", o0, 0); chk("clr drop", dc0, 0); chk("clr window", c1, 0);

      step(1'b0, 16'h00FF, 16'd1, 1'b0);
      step(1'b0, 16'h0100, 16'd2, 1'b0);
      step(1'b0, 16'h01FF, 16'd3, 1'b0);
      step(1'b0, 16'h0200, 16'd4, 1'b0);
      chk("win count", c1, 2); chk("win drop", dc1, 0);
      chk("win head addr", a1, 16'h0100); chk("win head data", d1, 2);
      rdy1 = 1'b1;
      step(1'b1, 16'h0, 16'h0, 1'b0);
      rdy1 = 1'b0;
      chk("win second addr", a1, 16'h01FF); chk("win second data", d1, 3); chk("win count2", c1, 1);
      clr = 1'b1;
      step(1'b1, 16'h0, 16'h0, 1'b0);
      clr = 1'b0;

      for (int i = 0; i < 20; i++) begin
         step(1'b0, 16'(16'h40 + i), 16'(i), 1'b1);
         chk($sformatf("thr%0d valid", i), v0, 1);
         chk($sformatf("thr%0d addr", i), a0, 16'(16'h40 + i));
         chk($sformatf("thr%0d data", i), d0, 16'(i));
         chk($sformatf("thr%0d count", i), c0, 1);
      end
      step(1'b1, 16'h0, 16'h0, 1'b1);
      chk("thr end valid", v0, 0); chk("thr end count", c0, 0);

      for (int i = 0; i < 266; i++) step(1'b0, 16'h0050, 16'(i), 1'b0);
      chk("sat drop", dc0, 255); chk("sat ovf", o0, 1); chk("sat full", f0, 1);
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0, 16'h0, 1'b1);
      chk("part count", c0, 5); chk("part head", d0, 3); chk("part ovf", o0, 1);
      clr = 1'b1;
      step(1'b0, 16'h0060, 16'h5555, 1'b0);
      clr = 1'b0;
      chk("clrw count", c0, 0); chk("clrw ovf", o0, 0); chk("clrw drop", dc0, 0); chk("clrw valid", v0, 0);
      step(1'b1, 16'h0, 16'h0, 1'b0);
      chk("clrw discard", v0, 0);

      for (int i = 0; i < 3; i++) step(1'b0, 16'(16'h70 + i), 16'(i), 1'b0);
      chk("refill count", c0, 3); chk("refill head", a0, 16'h0070);
      rst_n = 1'b0;
      step(1'b0, 16'h0080, 16'h9999, 1'b0);
      chk("mrst valid", v0, 0); chk("mrst count", c0, 0); chk("mrst addr", a0, 0);
      rst_n = 1'b1;
      step(1'b1, 16'h0, 16'h0, 1'b0);
      chk("mrst ignored", c0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
